// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: streams every WIDTH-bit word of popcount k in ascending order (Gosper successor).
// Optional popcount self-check output chk_err under WEIGHT_PATTERN_GEN_CHECK_EN.
module weight_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int CW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pattern,
  output logic             last,
  output logic [15:0]      seq_idx,
  output logic             done,
  output logic             err
`ifdef WEIGHT_PATTERN_GEN_CHECK_EN
  ,
  output logic             chk_err
`endif
);
  localparam int SW = $clog2(WIDTH + 1) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] k;
  logic [WIDTH:0] x, c, r;
  logic [SW-1:0] ctz;
  logic [WIDTH-1:0] nxt, top_k, top_w, init_w;
  logic go, bad, xfer;
  assign busy = state == RUN;
  assign out_valid = state == RUN;
  assign xfer = state == RUN && out_ready;
  assign go = state == IDLE && start && weight <= CW'(WIDTH);
  assign bad = state == IDLE && start && weight > CW'(WIDTH);
  assign top_k = ~({WIDTH{1'b1}} >> k);
  assign top_w = ~({WIDTH{1'b1}} >> weight);
  assign init_w = ~({WIDTH{1'b1}} << weight);
  // Gosper: lowest set bit carried up, the displaced ones re-packed at the bottom
  always_comb begin
    x = {1'b0, pattern};
    c = x & (-x);
    r = x + c;
    ctz = '0;
    for (int i = WIDTH; i >= 0; i--) if (c[i]) ctz = SW'(i);
    nxt = WIDTH'((((r ^ x) >> 2) >> ctz) | r);
  end
  always_comb state_nxt = (state == IDLE) ? (go ? RUN : IDLE) : ((out_ready && last) ? IDLE : RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      pattern <= '0;
      seq_idx <= '0;
      last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= xfer && last;
      err <= bad;
      if (go) begin
        k <= weight;
        pattern <= init_w;
        seq_idx <= '0;
        last <= init_w == top_w;
      end else if (xfer && !last) begin
        pattern <= nxt;
        seq_idx <= seq_idx + 16'd1;
        last <= nxt == top_k;
      end
    end
  end
`ifdef WEIGHT_PATTERN_GEN_CHECK_EN
  logic [CW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CW'(pattern[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_err <= 1'b0;
    else if (go) chk_err <= 1'b0;
    else if (xfer && pc != k) chk_err <= 1'b1;
`endif
endmodule
